// File: rtl/sign_narrow_16.sv
// sign_narrow_16: narrows a 32-bit signed value to a 16-bit immediate field.
// The 16->32 sign extender is the inverse block in the datapath.
//
// Pipeline: stage 0 is the combinational range check, stage 1 is a
// capture register, stage 2 selects the output and holds it until the
// output handshake completes. Both sides use valid/ready.
// Words that fail the round trip (narrow, then sign-extend) are flagged on
// out_ovf. They are either truncated or saturated, depending on sat_mode.
// A saturating counter tracks overflowed words delivered downstream.
//
// Optional build macro SIGN_NARROW_UNSIGNED_EN adds the unsigned_mode input.
// That input selects unsigned narrowing: range 0..FFFF, saturation to FFFF.
// When the macro is undefined the port is absent and only signed narrowing
// is built. The signed datapath is identical in both builds.
module sign_narrow_16 #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_data,
    input  logic               sat_mode,
`ifdef SIGN_NARROW_UNSIGNED_EN
    input  logic               unsigned_mode,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_imm,
    output logic               out_ovf,
    input  logic               clr_count,
    output logic [COUNT_W-1:0] ovf_count
);

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    // A signed value fits in IMM_W bits when bits [DATA_W-1:IMM_W-1] are all
    // copies of the sign bit. In that case sign extension restores it exactly.
    function automatic logic fits_signed(input logic [DATA_W-IMM_W:0] top);
        return (top == '0) || (top == '1);
    endfunction

    // An unsigned value fits when nothing is set above the immediate field.
    function automatic logic fits_unsigned(input logic [DATA_W-IMM_W-1:0] top);
        return (top == '0);
    endfunction

    // Saturation limit: the nearest representable extreme on the side of the
    // overflow. An unsigned overflow can only be too large.
    function automatic logic [IMM_W-1:0] sat_limit(input logic neg, input logic uns);
        logic [IMM_W-1:0] lim;
        if (uns)
            lim = {IMM_W{1'b1}};
        else if (neg)
            lim = {1'b1, {(IMM_W-1){1'b0}}};
        else
            lim = {1'b0, {(IMM_W-1){1'b1}}};
        return lim;
    endfunction

    // Output selection.
    // In-range words and truncate-mode overflows pass the low field.
    // Saturate-mode overflows clamp to the limit.
    function automatic logic [IMM_W-1:0] narrow(
        input logic [IMM_W-1:0] low,
        input logic             neg,
        input logic             fits,
        input logic             sat,
        input logic             uns
    );
        logic [IMM_W-1:0] res;
        if (fits || !sat)
            res = low;
        else
            res = sat_limit(neg, uns);
        return res;
    endfunction

    // ---- stage 0: combinational range check on the incoming word ----
    logic uns_p0;
    logic fits_p0;

`ifdef SIGN_NARROW_UNSIGNED_EN
    assign uns_p0 = unsigned_mode;
`else
    assign uns_p0 = 1'b0;
`endif

    assign fits_p0 = uns_p0 ? fits_unsigned(in_data[DATA_W-1:IMM_W])
                            : fits_signed(in_data[DATA_W-1:IMM_W-1]);

    // ---- stage 1: capture register ----
    // Only the low field and the sign bit are needed after the range check.
    logic             vld_p1;
    logic [IMM_W-1:0] low_p1;
    logic             neg_p1;
    logic             sat_p1;
    logic             uns_p1;
    logic             fits_p1;

    // ---- stage 2: output register ----
    logic             vld_p2;
    logic [IMM_W-1:0] imm_p2;
    logic             ovf_p2;

    logic adv2;
    logic xfer_out;

    // Stage 2 may load when it is empty or is being drained this cycle.
    // Stage 1 may accept when it is empty or is moving into stage 2.
    assign adv2     = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || adv2;
    assign xfer_out = vld_p2 && out_ready;

    // Stage 1 valid bit. It refills or empties whenever in_ready is high.
    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    // Stage 1 payload. It is captured only on an accepted input word.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            low_p1  <= in_data[IMM_W-1:0];
            neg_p1  <= in_data[DATA_W-1];
            sat_p1  <= sat_mode;
            uns_p1  <= uns_p0;
            fits_p1 <= fits_p0;
        end
    end

    // Stage 2 register. It holds its contents while stalled.
    // When it goes empty, out_imm keeps the last word delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            imm_p2 <= '0;
            ovf_p2 <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                imm_p2 <= narrow(low_p1, neg_p1, fits_p1, sat_p1, uns_p1);
                ovf_p2 <= !fits_p1;
            end
        end
    end

    // Overflow event counter. It counts delivered overflow words and sticks
    // at its maximum value. A clear takes priority over a same-cycle event.
    always_ff @(posedge clk) begin
        if (reset || clr_count)
            ovf_count <= '0;
        else if (xfer_out && ovf_p2 && (ovf_count != COUNT_MAX))
            ovf_count <= ovf_count + 1'b1;
    end

    assign out_valid = vld_p2;
    assign out_imm   = imm_p2;
    assign out_ovf   = ovf_p2;

endmodule

// File: tb/tb_sign_narrow_16.sv
// Testbench for sign_narrow_16.
// Two instances share one stimulus: one with COUNT_W=8 and one with
// COUNT_W=2, so the counter saturation can be observed.
module tb_sign_narrow_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        sat_mode;
    logic        unsig;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready,  in_ready_b;
    logic        out_valid, out_valid_b;
    logic [15:0] out_imm,   out_imm_b;
    logic        out_ovf,   out_ovf_b;
    logic [7:0]  ovf_count8;
    logic [1:0]  ovf_count2;

    always #5 clk = ~clk;

    sign_narrow_16 #(.COUNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sat_mode(sat_mode),
`ifdef SIGN_NARROW_UNSIGNED_EN
        .unsigned_mode(unsig),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_ovf(out_ovf), .clr_count(clr_count), .ovf_count(ovf_count8)
    );

    sign_narrow_16 #(.COUNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .sat_mode(sat_mode),
`ifdef SIGN_NARROW_UNSIGNED_EN
        .unsigned_mode(unsig),
`endif
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_ovf(out_ovf_b), .clr_count(clr_count), .ovf_count(ovf_count2)
    );

    typedef struct {
        logic [15:0] imm;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          lat_chk = 0;
    int          cnt8_m = 0;
    int          cnt2_m = 0;
    logic [31:0] wd[8];
    bit          ws[8];
    bit          wu[8];
    int          widx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model. It checks the range numerically, not bit-wise.
    function automatic exp_t model(input logic [31:0] d, input bit s, input bit u, input int acc);
        exp_t   e;
        longint v;
        bit     ok;
        v = longint'($signed(d));
        if (u) ok = (d <= 32'h0000FFFF);
        else   ok = (v >= -32768) && (v <= 32767);
        e.ovf = !ok;
        if (ok || !s)  e.imm = d[15:0];
        else if (u)    e.imm = 16'hFFFF;
        else if (v < 0) e.imm = 16'h8000;
        else           e.imm = 16'h7FFF;
        e.acc = acc;
        return e;
    endfunction

    task automatic setw(input int i, input logic [31:0] d, input bit s, input bit u);
        wd[i] = d; ws[i] = s; wu[i] = u;
    endtask

    // Offer words wd[widx..n-1] for a fixed number of cycles.
    // Each accepted word is pushed to the scoreboard.
    task automatic push_words(input int n, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bit acc;
            in_valid = (widx < n);
            if (widx < n) begin
                in_data = wd[widx]; sat_mode = ws[widx]; unsig = wu[widx];
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) q.push_back(model(in_data, sat_mode, unsig, cyc + 1));
            @(posedge clk); #1;
            if (acc) widx++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_done", 32'(t < 50), 32'd1);
    endtask

    // Output monitor and counter model.
    // It samples on the falling edge; the transfer happens at the next rise.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            cnt8_m = 0;
            cnt2_m = 0;
        end else begin
            check("ovf_count8", 32'(ovf_count8), 32'(cnt8_m));
            check("ovf_count2", 32'(ovf_count2), 32'(cnt2_m));
            check("out_valid_b", 32'(out_valid_b), 32'(out_valid));
            check("in_ready_b", 32'(in_ready_b), 32'(in_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q[0];
                    check("out_imm", 32'(out_imm), 32'(e.imm));
                    check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                    check("out_imm_b", 32'(out_imm_b), 32'(e.imm));
                    if (out_ready) begin
                        if (lat_chk) check("latency", cyc, e.acc + 1);
                        void'(q.pop_front());
                        if (!clr_count && e.ovf) begin
                            if (cnt8_m < 255) cnt8_m++;
                            if (cnt2_m < 3)   cnt2_m++;
                        end
                    end
                end
            end
            if (clr_count) begin
                cnt8_m = 0;
                cnt2_m = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; sat_mode = 1'b0; unsig = 1'b0;
        out_ready = 1'b1; clr_count = 1'b0;
        for (int i = 0; i < 8; i++) setw(i, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", 32'(out_imm), 32'h0000);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_count", 32'(ovf_count8), 32'd0);

        // In-range boundary stream, back to back
        lat_chk = 1;
        setw(0, 32'h00007FFF, 0, 0); setw(1, 32'hFFFF8000, 0, 0);
        setw(2, 32'h00000000, 0, 0); setw(3, 32'hFFFFFFFF, 0, 0);
        widx = 0; push_words(4, 4);
        check("stream_accepts", widx, 4);
        drain();
        check("stream_count", 32'(ovf_count8), 32'd0);

        // Overflow: truncate and saturate, both signs
        setw(0, 32'h00008000, 0, 0); setw(1, 32'h00008000, 1, 0);
        setw(2, 32'h80000000, 1, 0);
        widx = 0; push_words(3, 3);
        drain();
        check("ovf_count3", 32'(ovf_count8), 32'd3);
        check("empty_hold_imm", 32'(out_imm), 32'h8000);
        check("empty_valid", 32'(out_valid), 32'd0);

        // Backpressure: 5 words with the sink stalled
        lat_chk = 0; out_ready = 1'b0;
        setw(0, 32'h00000001, 0, 0); setw(1, 32'hFFFFFFFE, 0, 0);
        setw(2, 32'h00012345, 0, 0); setw(3, 32'h00007FFF, 1, 0);
        setw(4, 32'hFFFF0000, 1, 0);
        widx = 0; push_words(5, 4);
        check("bp_accepts", widx, 2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_imm", 32'(out_imm), 32'h0001);
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'd1);
        push_words(5, 8);
        check("bp_all_accepted", widx, 5);
        drain();

        // Counter saturation on the 2-bit instance, then clear during a transfer
        clr_count = 1'b1; @(posedge clk); #1 clr_count = 1'b0;
        check("clr_idle8", 32'(ovf_count8), 32'd0);
        check("clr_idle2", 32'(ovf_count2), 32'd0);
        lat_chk = 1;
        setw(0, 32'h12345678, 0, 0); setw(1, 32'h87654321, 1, 0);
        setw(2, 32'h00010000, 0, 0); setw(3, 32'hFFFE0000, 1, 0);
        setw(4, 32'h7FFFFFFF, 1, 0);
        widx = 0; push_words(5, 5);
        drain();
        check("sat_count2", 32'(ovf_count2), 32'd3);
        check("sat_count8", 32'(ovf_count8), 32'd5);
        lat_chk = 0; out_ready = 1'b0;
        setw(0, 32'h40000000, 1, 0);
        widx = 0; push_words(1, 3);
        check("clr_word_waiting", 32'(out_valid), 32'd1);
        out_ready = 1'b1; clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        check("clr_wins8", 32'(ovf_count8), 32'd0);
        check("clr_wins2", 32'(ovf_count2), 32'd0);
        drain();

        // Reset while both stages are full
        setw(0, 32'h00020000, 0, 0);
        widx = 0; push_words(1, 1);
        drain();
        check("pre_rst_count", 32'(ovf_count8), 32'd1);
        out_ready = 1'b0;
        setw(0, 32'h00000055, 0, 0); setw(1, 32'h00040000, 1, 0);
        widx = 0; push_words(2, 3);
        check("full_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_count", 32'(ovf_count8), 32'd0);
        out_ready = 1'b1; lat_chk = 1;
        setw(0, 32'hFFFF8001, 0, 0);
        widx = 0; push_words(1, 1);
        drain();

`ifdef SIGN_NARROW_UNSIGNED_EN
        // Unsigned narrowing
        setw(0, 32'h0000FFFF, 0, 1); setw(1, 32'h00010000, 1, 1);
        setw(2, 32'hFFFFFFFF, 0, 1); setw(3, 32'hFFFFFFFF, 0, 0);
        widx = 0; push_words(4, 4);
        drain();
        check("uns_count", 32'(ovf_count8), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_narrow_16.md
Name: sign_narrow_16

Overview:
- Inverse of the datapath's 16→32 immediate sign extender. Narrows a 32-bit signed value to a 16-bit immediate field.
- Flags values that do not survive the round trip narrow → sign-extend, and optionally saturates them.
- Sits between ALU result / assembler-helper logic and the instruction immediate packer.
- 2-stage pipeline with valid/ready handshake on both sides and a saturating overflow-event counter.

Parameters:
- COUNT_W, 8, width of the overflow event counter (1..16).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/sat_mode are valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  32  signed value to narrow
- sat_mode  input  1  0 = truncate, 1 = saturate; sampled with in_data
- out_valid  output  1  out_imm/out_ovf are valid
- out_ready  input  1  downstream accepts this cycle
- out_imm  output  16  narrowed immediate
- out_ovf  output  1  in_data not representable in signed 16 bits
- clr_count  input  1  synchronous clear of ovf_count
- ovf_count  output  COUNT_W  count of overflowed words delivered

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset (reset high at posedge):
  - s1_valid=0, out_valid=0, out_imm=16'h0000, out_ovf=0, ovf_count=0.
  - All in-flight words are discarded, including reset asserted mid-transfer.
  - in_ready=1 in the first cycle after reset deasserts.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Once asserted, out_valid, out_imm and out_ovf hold stable until the output transfer.
- Stage 1 register: captures in_data, sat_mode and fits. fits = (in_data[31:15] all 0) or (all 1).
- Stage 2 (output) register:
  - out_ovf = !fits.
  - fits=1 → out_imm = in_data[15:0].
  - fits=0, sat_mode=0 → out_imm = in_data[15:0] (truncate).
  - fits=0, sat_mode=1 → out_imm = in_data[31] ? 16'h8000 : 16'h7FFF.
- Advance logic:
  - adv2 = !out_valid || out_ready. Stage 1 moves into stage 2 when s1_valid && adv2.
  - in_ready = !s1_valid || adv2, purely combinational from state and out_ready.
- Latency and throughput:
  - Latency is 2 cycles: a word accepted at edge N sets out_valid after edge N+1 if unstalled.
  - Throughput is 1 word/cycle with out_ready held high.
  - No bubbles are inserted. No word is dropped or duplicated under any valid/ready pattern.
- Full condition: both stages valid and out_ready=0 → in_ready=0. Stall resolves in the same cycle out_ready rises.
- Empty condition: out_valid=0, and out_imm holds its last value.
- Round-trip invariant: whenever out_ovf=0, sign-extending out_imm reproduces the original in_data exactly.
- ovf_count:
  - Increments by 1 on each output transfer with out_ovf=1.
  - Saturates at 2^COUNT_W-1, no wrap.
  - clr_count sets it to 0. clr_count wins over a simultaneous increment, and that event is lost.
- sat_mode changes affect only subsequently accepted words.

Optional Feature:
- Macro: SIGN_NARROW_UNSIGNED_EN.
- Defined:
  - Adds input port unsigned_mode (1 bit), sampled with in_data.
  - When unsigned_mode=1: fits = (in_data[31:16] == 0); saturate value = 16'hFFFF; truncate passes in_data[15:0].
  - unsigned_mode=0 behaves exactly as signed mode.
- Not defined: the port is absent and only signed narrowing exists. The signed datapath is bit-identical in both builds.

Test Plan:
- Reset, then stream 32'h00007FFF, 32'hFFFF8000, 32'h00000000, 32'hFFFFFFFF with out_ready=1. Required response:
  - out_imm = 7FFF, 8000, 0000, FFFF on 4 consecutive cycles starting 2 cycles after the first accept.
  - out_ovf=0 for all four; ovf_count=0.
- in_data=32'h00008000, sat_mode=0 → out_imm=8000, out_ovf=1. Same input with sat_mode=1 → out_imm=7FFF, out_ovf=1. in_data=32'h80000000, sat_mode=1 → out_imm=8000. Final ovf_count=3.
- Backpressure:
  - Push 5 words with out_ready=0. in_ready must fall after 2 accepts; out_imm holds the first word.
  - Release out_ready. All 5 words emerge in order, no loss or duplication.
- COUNT_W=2: send 5 overflowing words → ovf_count sticks at 3. Assert clr_count in the same cycle as a 6th overflow transfer → ovf_count=0.
- Assert reset while both stages are full → next cycle out_valid=0, in_ready=1, ovf_count=0. A fresh word then emerges with 2-cycle latency.
- With SIGN_NARROW_UNSIGNED_EN, unsigned_mode=1:
  - 32'h0000FFFF → out_imm=FFFF, out_ovf=0.
  - 32'h00010000 with sat_mode=1 → out_imm=FFFF, out_ovf=1.
